// File: rtl/cam_capture_rgb332.sv
// cam_capture_rgb332
//   Receives the OV7670 parallel pixel stream on pclk. Each RGB565 byte pair
//   becomes one RGB332 pixel, and the pixel is written sequentially into the
//   frame-buffer write port of the dual-port RAM.
//
// Ports
//   pclk            camera pixel clock. This is the only clock (rising edge).
//   rst             asynchronous reset, active low
//   CAM_vsync       high = frame blanking. A frame starts on its falling edge.
//   CAM_href        high = CAM_px_data carries a valid byte this cycle
//   CAM_px_data     camera byte
//   capture_en      level input. Arms capture of the next frame.
//   DP_RAM_addr_in  write address. Holds its value between writes.
//   DP_RAM_data_in  RGB332 pixel. Holds its value between writes.
//   DP_RAM_regW     write strobe, one pclk wide per pixel
//   frame_done      one-cycle pulse after a complete frame
//   overflow        sticky. Set when more than IMG_W*IMG_H pixels arrive in a frame.
module cam_capture_rgb332 #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 8
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  input  logic          capture_en,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          overflow
);

  // The counter is one bit wider than the address.
  // This lets it hold IMG_W*IMG_H even when the frame fills the address space exactly.
  localparam logic [AW:0] TOTAL = (AW+1)'(IMG_W * IMG_H);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

  state_t      state, nxt;
  logic        vsync_d;
  logic        fall, rise;
  logic        phase;
  logic [5:0]  byte1;      // only the R5 and G-high bits of the first byte are kept
  logic [AW:0] pix_cnt;
  logic        full;
  logic [7:0]  pixel;

  // Inputs are already in the pclk domain, so no synchronizers are used.
  assign fall  = vsync_d & ~CAM_vsync;
  assign rise  = ~vsync_d & CAM_vsync;
  assign full  = (pix_cnt == TOTAL);
  // R3 = R5[4:2], G3 = G6[5:3], B2 = B5[4:3]
  assign pixel = {byte1, CAM_px_data[4:3]};

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (capture_en) nxt = WAIT_SOF;
      WAIT_SOF: begin
        if (!capture_en) nxt = IDLE;
        else if (fall)   nxt = CAPTURE;
      end
      // capture_en is ignored while a frame is in progress.
      // A truncated frame re-arms unconditionally.
      // WAIT_SOF drops back to IDLE if capture_en is low.
      CAPTURE: begin
        if (rise) nxt = (full && !capture_en) ? IDLE : WAIT_SOF;
      end
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_d        <= 1'b0;
      phase          <= 1'b0;
      byte1          <= '0;
      pix_cnt        <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      vsync_d     <= CAM_vsync;
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_SOF: begin
          if (capture_en && fall) begin
            pix_cnt  <= '0;
            phase    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (rise) begin
            // End of frame wins over a byte sampled on the same edge.
            phase      <= 1'b0;
            frame_done <= full;
          end else if (CAM_href) begin
            if (!phase) begin
              byte1 <= {CAM_px_data[7:5], CAM_px_data[2:0]};
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (pix_cnt < TOTAL) begin
                DP_RAM_data_in <= DW'(pixel);
                DP_RAM_addr_in <= pix_cnt[AW-1:0];
                DP_RAM_regW    <= 1'b1;
                pix_cnt        <= pix_cnt + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else begin
            // A gap in href drops any half pixel, so every line starts aligned.
            phase <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cam_capture_rgb332.md
Name: cam_capture_rgb332

Overview:
- Synthesizable receiver for the OV7670 parallel pixel interface: CAM_vsync, CAM_href and CAM_px_data, clocked by the camera pclk.
- Assembles each RGB565 byte pair into one RGB332 pixel.
- Writes pixels sequentially into the frame-buffer write port of the dual-port RAM that the VGA side reads.
- Sits inside test_cam between the camera pins and the DP_RAM write port.

Parameters:
IMG_W, 160, pixels per line (each pixel is 2 camera bytes, so a line is 320 bytes)
IMG_H, 120, lines per frame
AW, 15, frame-buffer address width; must satisfy 2^AW >= IMG_W*IMG_H (19200)
DW, 8, frame-buffer data width (RGB332)

Ports:
pclk  in  1  camera pixel clock; the only clock; every register uses its rising edge
rst  in  1  asynchronous, active-low reset
CAM_vsync  in  1  high = frame blanking/sync; frame starts on its falling edge
CAM_href  in  1  high = valid byte on CAM_px_data this cycle
CAM_px_data  in  8  camera byte
capture_en  in  1  level; allows capture of the next frame
DP_RAM_addr_in  out  AW  write address
DP_RAM_data_in  out  DW  RGB332 pixel
DP_RAM_regW  out  1  write strobe, one pclk wide per pixel
frame_done  out  1  one-cycle pulse when a full frame has been written
overflow  out  1  sticky; a pixel arrived after IMG_W*IMG_H writes in this frame

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; internal pixel counter 0; byte phase 0; FSM state IDLE.
  - Reset mid-frame aborts the frame with no write and no frame_done.
- Edge detection: vsync_d is a registered copy of CAM_vsync.
  - fall = vsync_d & ~CAM_vsync
  - rise = ~vsync_d & CAM_vsync
  - No synchronizers: inputs are already in the pclk domain.
- FSM states:
  - IDLE: go to WAIT_SOF when capture_en=1.
  - WAIT_SOF: on fall, go to CAPTURE; clear pix_cnt, byte phase and overflow. If capture_en drops, go to IDLE.
  - CAPTURE: byte handling is described below.
    - On rise with pix_cnt==IMG_W*IMG_H: pulse frame_done, then go to WAIT_SOF if capture_en=1, else IDLE.
    - On rise with pix_cnt short (truncated frame): no frame_done; go to WAIT_SOF.
    - capture_en changes are ignored in CAPTURE; the frame is always finished.
- Byte handling in CAPTURE, each pclk with CAM_href=1:
  - Phase 0: store byte1 = CAM_px_data; phase becomes 1.
  - Phase 1: phase becomes 0 and the pixel is {byte1[7:5], byte1[2:0], CAM_px_data[4:3]} (R3 from R5 MSBs, G3 from G6 MSBs, B2 from B5 MSBs).
    - If pix_cnt < IMG_W*IMG_H, on that same edge: DP_RAM_data_in <= pixel, DP_RAM_addr_in <= pix_cnt, DP_RAM_regW <= 1, pix_cnt <= pix_cnt+1.
    - Otherwise set overflow=1 and make no write.
- Write strobe and latency:
  - DP_RAM_regW returns to 0 on the next edge.
  - Latency is 1 pclk: the strobe, address and data are valid in the cycle after the second byte is sampled.
  - DP_RAM_addr_in and DP_RAM_data_in hold their values between writes.
- CAM_href=0 in CAPTURE clears the byte phase, so an odd byte count in a line discards the partial pixel.
- Simultaneous events: rise takes priority over byte handling in the same cycle, so no write occurs on that edge.
- Address runs linearly 0..IMG_W*IMG_H-1 and never wraps within a frame.

Test Plan:
1. Default TB camera model, CAM_px_data=0xE0, capture_en=1:
   - 19200 DP_RAM_regW pulses per frame, addresses 0..19199 in order, every data 0xE0.
   - frame_done pulses once, on the vsync rising edge.
2. Byte pair 0xF8,0x1F (pure red, then blue bits):
   - data = {111,000,11} = 0xE3.
   - Pair 0x07,0xE0 gives 0x1C.
   - Strobe is exactly 1 cycle, 1 pclk after the second byte.
3. Lines of 321 bytes (odd count):
   - 160 writes per line; the trailing byte is discarded.
   - Next line starts on phase 0 (checked by data of the first pixel).
4. Frame of 121 lines:
   - Writes stop at addr 19199; overflow=1.
   - frame_done still pulses; overflow clears at the next vsync fall.
5. vsync rises after 50 lines:
   - No frame_done; next frame restarts at addr 0.
   - rst=0 asserted mid-line: all outputs 0 immediately (asynchronous), no further writes until a new vsync fall.
6. capture_en=0 before vsync fall: no writes that frame. capture_en=0 mid-frame: current frame completes with 19200 writes, then the FSM stays in IDLE.
